spi_flash_responder: RTL

Flash-side end of the controller's byte-wide SPI link: a behavioural-synthesisable NOR-flash responder that decodes the command/address/data byte stream driven by the APB-to-SPI controller and services 32-bit word reads and writes from an internal array. One byte moves per `s_clk` rising edge while `s_css` is low. It serves as the target model in controller benches and as the on-chip flash stand-in for FPGA bring-up.

---
 rtl/spi_flash_responder.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/spi_flash_responder.sv
`default_nettype none
// ============================================================================
//  Module      : spi_flash_responder
//  Description : Flash-side end of the byte-wide SPI link. It decodes the
//                command, address and data bytes of each frame and serves
//                32-bit word reads and writes from an internal array that
//                resets to the NOR erased value.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
    parameter int         MEM_AW    = 8,
    parameter logic [7:0] CMD_READ  = 8'h01,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic       s_clk,
    input  logic       s_reset,
    input  logic       s_css,
    input  logic [7:0] s_mosi,
    output logic [7:0] s_miso,
    input  logic       s_wp,
    output logic       busy,
    output logic       wr_done,
    output logic       rd_done,
    output logic       frame_err
);

    localparam int c_DEPTH = 1 << MEM_AW;

    // CMD is passed through on the command edge itself, so it is never held,
    // but it still counts as an in-frame state for abort reporting.
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_CMD    = 3'd1;
    localparam logic [2:0] c_ST_ADDR   = 3'd2;
    localparam logic [2:0] c_ST_DATA   = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;
    localparam logic [2:0] c_ST_IGNORE = 3'd5;

    logic [2:0]        r_state;
    logic [2:0]        r_cnt;
    logic              r_dir_wr;
    logic [MEM_AW-1:0] r_idx;      // only the address bits that select a word
    logic [23:0]       r_shift;    // first three write data bytes
    logic [23:0]       r_rd_lo;    // low three bytes of the fetched word
    logic [7:0]        r_miso;
    logic              r_busy;
    logic              r_wr_done;
    logic              r_rd_done;
    logic              r_frame_err;
    logic [31:0]       r_mem [c_DEPTH];

    logic [MEM_AW-1:0] w_idx;
    logic [31:0]       w_fetch;
    logic [31:0]       w_wr_word;
    logic              w_in_frame;

    // Address bytes are shifted through an index-wide register, so bits above
    // the array size fall off and indices wrap naturally.
    assign w_idx      = MEM_AW'({r_idx, s_mosi});
    assign w_fetch    = r_mem[w_idx];
    assign w_wr_word  = {r_shift, s_mosi};
    assign w_in_frame = (r_state == c_ST_CMD) || (r_state == c_ST_ADDR) ||
                        (r_state == c_ST_DATA);

    assign s_miso    = r_miso;
    assign busy      = r_busy;
    assign wr_done   = r_wr_done;
    assign rd_done   = r_rd_done;
    assign frame_err = r_frame_err;

    // Frame decoder, byte counter, registered outputs and the word array.
    always_ff @(posedge s_clk) begin
        if (s_reset) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= 3'd0;
            r_dir_wr    <= 1'b0;
            r_idx       <= '0;
            r_shift     <= 24'h0;
            r_rd_lo     <= 24'h0;
            r_miso      <= 8'h00;
            r_busy      <= 1'b0;
            r_wr_done   <= 1'b0;
            r_rd_done   <= 1'b0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_mem[i] <= 32'hFFFF_FFFF;
            end
        end else begin
            r_wr_done   <= 1'b0;
            r_rd_done   <= 1'b0;
            r_frame_err <= 1'b0;
            if (s_css) begin
                // Deselect: a frame cut short before its last byte is an error.
                r_frame_err <= w_in_frame;
                r_state     <= c_ST_IDLE;
                r_cnt       <= 3'd0;
                r_miso      <= 8'h00;
                r_busy      <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + 3'd1;
                r_busy <= 1'b1;
                case (r_state)
                    c_ST_IDLE: begin
                        r_idx  <= '0;
                        r_miso <= 8'h00;
                        if (s_mosi == CMD_READ) begin
                            r_dir_wr <= 1'b0;
                            r_state  <= c_ST_ADDR;
                        end else if (s_mosi == CMD_WRITE) begin
                            r_dir_wr <= 1'b1;
                            r_state  <= c_ST_ADDR;
                        end else begin
                            r_state     <= c_ST_IGNORE;
                            r_frame_err <= 1'b1;
                        end
                    end
                    c_ST_CMD: begin
                        r_miso      <= 8'h00;
                        r_state     <= c_ST_IGNORE;
                        r_frame_err <= 1'b1;
                    end
                    c_ST_ADDR: begin
                        r_idx  <= w_idx;
                        r_miso <= 8'h00;
                        if (r_cnt == 3'd3) begin
                            r_state <= c_ST_DATA;
                            if (!r_dir_wr) begin
                                r_miso  <= w_fetch[31:24];
                                r_rd_lo <= w_fetch[23:0];
                            end
                        end
                    end
                    c_ST_DATA: begin
                        if (r_dir_wr) begin
                            r_miso  <= 8'h00;
                            r_shift <= {r_shift[15:0], s_mosi};
                            if (r_cnt == 3'd7) begin
                                r_state <= c_ST_DONE;
                                if (s_wp) begin
                                    r_frame_err <= 1'b1;
                                end else begin
                                    r_mem[r_idx] <= w_wr_word;
                                    r_wr_done    <= 1'b1;
                                end
                            end
                        end else begin
                            case (r_cnt)
                                3'd4:    r_miso <= r_rd_lo[23:16];
                                3'd5:    r_miso <= r_rd_lo[15:8];
                                3'd6:    r_miso <= r_rd_lo[7:0];
                                default: r_miso <= 8'h00;
                            endcase
                            if (r_cnt == 3'd7) begin
                                r_rd_done <= 1'b1;
                                r_state   <= c_ST_DONE;
                            end
                        end
                    end
                    default: begin
                        // DONE / IGNORE: swallow bytes until deselect.
                        r_miso <= 8'h00;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
